// File: rtl/mmu_gen2_if.sv
// mmu_gen2_if: data-side request bus between a CPU core (master) and the
// MMU (slave).
//   dm_req     request, held by the master while dm_stall is high
//   dm_we      1 = store, 0 = load
//   dm_addr    byte address
//   dm_di      right-aligned store data
//   dm_size    0 = byte, 1 = half, 2 = word, 3 = illegal
//   dm_signed  sign-extend loads
//   dm_do      aligned/extended load data
//   dm_valid   access complete (one-cycle pulse)
//   dm_stall   request not being taken / access in progress
//   dm_fault   access aborted (pulses together with dm_valid)
interface mmu_gen2_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_di;
  logic [1:0]  dm_size;
  logic        dm_signed;
  logic [31:0] dm_do;
  logic        dm_valid;
  logic        dm_stall;
  logic        dm_fault;

  modport master (
    output dm_req, dm_we, dm_addr, dm_di, dm_size, dm_signed,
    input  dm_do, dm_valid, dm_stall, dm_fault
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_di, dm_size, dm_signed,
    output dm_do, dm_valid, dm_stall, dm_fault
  );
endinterface

// File: rtl/mmu_gen2.sv
// mmu_gen2: memory management unit joining an instruction fetch port, a data
// port (RAM or memory-mapped I/O) and an instruction-cache fence that copies
// the data RAM into the fetch RAM.
//   clk, resetb        clock, synchronous active-low reset
//   im_addr / im_do    fetch byte address / fetched word (ram0 read data)
//   dm                 data request bus (mmu_gen2_if slave side)
//   ram0_*             fetch/fill RAM port (word address, we, write/read data)
//   ram1_*             data RAM port (word address, byte enables, write/read data)
//   io_*               I/O request strobe, write, offset, write data, read data, ready
//   fence_i / fence_i_done  copy request / copy complete
module mmu_gen2 #(
  parameter int unsigned RAM_AW     = 14,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000,
  parameter int unsigned IO_AW      = 8,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [31:0]       im_addr,
  output logic [31:0]       im_do,
  mmu_gen2_if.slave         dm,
  output logic [RAM_AW-1:0] ram0_addr,
  output logic              ram0_we,
  output logic [31:0]       ram0_di,
  input  logic [31:0]       ram0_do,
  output logic [RAM_AW-1:0] ram1_addr,
  output logic [3:0]        ram1_be,
  output logic [31:0]       ram1_di,
  input  logic [31:0]       ram1_do,
  output logic              io_en,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready,
  input  logic              fence_i,
  output logic              fence_i_done
);
  localparam int unsigned     TW        = $clog2(IO_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(IO_TIMEOUT - 1);
  localparam logic [33:0]     RAM_BYTES = 34'd1 << (RAM_AW + 2);
  localparam logic [32:0]     IO_BYTES  = 33'd1 << IO_AW;
  localparam logic [RAM_AW:0] PTR_LAST  = {1'b1, {RAM_AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, RAM_RD, IO_WAIT, FENCE, DONE} state_t;
  state_t state, state_nx;

  logic [RAM_AW:0]    ptr;
  logic [TW-1:0]      tmo_cnt;
  logic               valid_q, fault_q;
  logic [31:0]        do_q;
  logic [1:0]         lane_q, size_q;
  logic               signed_q;
  logic               io_en_q, io_we_q;
  logic [IO_AW-1:0]   io_addr_q;
  logic [31:0]        io_wdata_q;

  logic [32:0] io_off;
  logic        hit_ram, hit_io, misalign, bad;
  logic        accept_state, take_fence, accept;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        unused_im;

  assign im_do     = ram0_do;
  assign unused_im = ^{im_addr[31:RAM_AW+2], im_addr[1:0]};

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (size)
      2'd0:    load_ext = {{24{sgn & s[7]}}, s[7:0]};
      2'd1:    load_ext = {{16{sgn & s[15]}}, s[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Request decode. An address below IO_BASE borrows into io_off[32], which
  // makes the window compare fail without a separate lower-bound test.
  always_comb begin
    io_off  = {1'b0, dm.dm_addr} - {1'b0, IO_BASE};
    hit_ram = {2'b00, dm.dm_addr} < RAM_BYTES;
    hit_io  = io_off < IO_BYTES;
    case (dm.dm_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = dm.dm_addr[0];
      2'd2:    misalign = dm.dm_addr[1:0] != 2'b00;
      default: misalign = 1'b1;
    endcase
    bad = misalign | ~(hit_ram | hit_io);
    case (dm.dm_size)
      2'd0:    be = 4'b0001 << dm.dm_addr[1:0];
      2'd1:    be = 4'b0011 << dm.dm_addr[1:0];
      default: be = 4'b1111;
    endcase
    case (dm.dm_size)
      2'd0:    wdata = {4{dm.dm_di[7:0]}};
      2'd1:    wdata = {2{dm.dm_di[15:0]}};
      default: wdata = dm.dm_di;
    endcase
    // RAM_RD only presents load data, so it can take the next request too.
    accept_state = (state == IDLE) || (state == RAM_RD);
    take_fence   = accept_state && fence_i;
    accept       = accept_state && dm.dm_req && !fence_i;
  end

  always_ff @(posedge clk) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RAM_RD: begin
        if (take_fence)                          state_nx = FENCE;
        else if (accept && !bad && hit_io)       state_nx = IO_WAIT;
        else if (accept && !bad && !dm.dm_we)    state_nx = RAM_RD;
        else                                     state_nx = IDLE;
      end
      IO_WAIT: if (io_ready || tmo_cnt == TMO_LAST) state_nx = IDLE;
      FENCE:   if (ptr == PTR_LAST)                 state_nx = DONE;
      DONE:    if (!fence_i)                        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      ptr        <= '0;
      tmo_cnt    <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      do_q       <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      io_en_q    <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      do_q    <= '0;
      ptr     <= (state == FENCE) ? ptr + 1'b1 : '0;
      tmo_cnt <= (state == IO_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (accept) begin
        lane_q   <= dm.dm_addr[1:0];
        size_q   <= dm.dm_size;
        signed_q <= dm.dm_signed;
        if (bad) begin
          valid_q <= 1'b1;
          fault_q <= 1'b1;
        end else if (hit_io) begin
          io_en_q    <= 1'b1;
          io_we_q    <= dm.dm_we;
          io_addr_q  <= io_off[IO_AW-1:0];
          io_wdata_q <= wdata;
        end else if (dm.dm_we) begin
          valid_q <= 1'b1;
        end
      end
      if (state == IO_WAIT) begin
        if (io_ready) begin
          valid_q <= 1'b1;
          do_q    <= io_we_q ? '0 : load_ext(io_rdata, lane_q, size_q, signed_q);
          io_en_q <= 1'b0;
        end else if (tmo_cnt == TMO_LAST) begin
          valid_q <= 1'b1;
          fault_q <= 1'b1;
          io_en_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ram0_addr    = im_addr[RAM_AW+1:2];
    ram0_we      = 1'b0;
    ram0_di      = ram1_do;
    ram1_addr    = dm.dm_addr[RAM_AW+1:2];
    ram1_be      = '0;
    ram1_di      = wdata;
    dm.dm_valid  = valid_q;
    dm.dm_fault  = fault_q;
    dm.dm_do     = do_q;
    dm.dm_stall  = 1'b0;
    fence_i_done = 1'b0;
    io_en        = io_en_q;
    io_we        = io_we_q;
    io_addr      = io_addr_q;
    io_wdata     = io_wdata_q;
    unique case (state)
      IDLE, RAM_RD: begin
        if (state == RAM_RD) begin
          dm.dm_valid = 1'b1;
          dm.dm_do    = load_ext(ram1_do, lane_q, size_q, signed_q);
        end
        dm.dm_stall = fence_i;
        if (accept && !bad && !hit_io && dm.dm_we) ram1_be = be;
      end
      IO_WAIT: dm.dm_stall = 1'b1;
      // ram1 read data lags its address by a cycle, so word p-1 is written
      // while word p is being read.
      FENCE: begin
        dm.dm_stall = 1'b1;
        ram1_addr   = ptr[RAM_AW-1:0];
        ram0_addr   = RAM_AW'(ptr - 1'b1);
        ram0_we     = ptr != '0;
      end
      DONE: begin
        dm.dm_stall  = 1'b1;
        fence_i_done = 1'b1;
      end
      default: ;
    endcase
    // Reset is synchronous, so block every strobe while it is held.
    if (!resetb) begin
      ram0_we      = 1'b0;
      ram1_be      = '0;
      dm.dm_valid  = 1'b0;
      dm.dm_fault  = 1'b0;
      dm.dm_do     = '0;
      dm.dm_stall  = 1'b0;
      fence_i_done = 1'b0;
      io_en        = 1'b0;
      io_we        = 1'b0;
    end
  end
endmodule

// File: tb/tb_mmu_gen2.sv
// tb_mmu_gen2: directed and random checks of mmu_gen2 against a byte-level
// memory model, an I/O responder with programmable latency and a fence copy.
module tb_mmu_gen2;
  localparam int unsigned AW      = 7;
  localparam int unsigned WORDS   = 1 << AW;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam int unsigned IO_TMO  = 15;

  logic clk = 1'b0;
  logic resetb;
  logic [31:0] im_addr, im_do;
  logic [AW-1:0] ram0_addr, ram1_addr;
  logic ram0_we;
  logic [3:0] ram1_be;
  logic [31:0] ram0_di, ram1_di, ram0_do, ram1_do;
  logic io_en, io_we, io_ready;
  logic [7:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic fence_i, fence_i_done;

  mmu_gen2_if bus ();

  mmu_gen2 #(.RAM_AW(AW), .IO_BASE(IO_BASE), .IO_AW(8), .IO_TIMEOUT(IO_TMO)) dut (
    .clk(clk), .resetb(resetb), .im_addr(im_addr), .im_do(im_do), .dm(bus),
    .ram0_addr(ram0_addr), .ram0_we(ram0_we), .ram0_di(ram0_di), .ram0_do(ram0_do),
    .ram1_addr(ram1_addr), .ram1_be(ram1_be), .ram1_di(ram1_di), .ram1_do(ram1_do),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready), .fence_i(fence_i), .fence_i_done(fence_i_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [0:4*WORDS-1];
  logic [31:0] seed [0:WORDS-1];
  logic [31:0] mem0 [0:WORDS-1];
  logic [31:0] mem1 [0:WORDS-1];
  logic mem_load;
  int r0_writes = 0;
  int unsigned io_lat;
  int unsigned io_cnt = 0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < WORDS; k++) begin
        mem1[k] <= seed[k];
        mem0[k] <= ~seed[k];
      end
    end else begin
      ram1_do <= mem1[ram1_addr];
      ram0_do <= mem0[ram0_addr];
      for (int b = 0; b < 4; b++)
        if (ram1_be[b]) mem1[ram1_addr][8*b +: 8] <= ram1_di[8*b +: 8];
      if (ram0_we) begin
        mem0[ram0_addr] <= ram0_di;
        r0_writes <= r0_writes + 1;
      end
    end
  end

  always @(posedge clk) io_cnt <= io_en ? io_cnt + 1 : 0;
  assign io_ready = io_en && (io_lat != 0) && (io_cnt == io_lat - 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic sgn);
    logic [31:0] r;
    r = v;
    if (sgn && n < 4 && v[8*n-1]) r = v | (32'hFFFF_FFFF << (8*n));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input logic sgn);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr+i]) << (8*i));
    return extend(v, n, sgn);
  endfunction

  function automatic logic [31:0] io_load(input logic [31:0] word, input logic [31:0] addr,
                                          input int n, input logic sgn);
    logic [31:0] v;
    logic [31:0] byte_val;
    v = '0;
    for (int i = 0; i < n; i++) begin
      byte_val = (word >> (8*((addr + i) % 4))) & 32'hFF;
      v = v | (byte_val << (8*i));
    end
    return extend(v, n, sgn);
  endfunction

  function automatic logic [31:0] ref_word(input int k);
    return {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
  endfunction

  // observations of the most recent access
  logic r_acc, r_valid, r_fault, r_after, r_io_en, r_io_we;
  logic [31:0] r_do;
  logic [3:0] r_be;
  logic [7:0] r_io_addr;
  int r_stalls, r_lat;

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] di,
                        input logic [1:0] size, input logic sgn);
    logic st;
    bit got;
    bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr;
    bus.dm_di = di; bus.dm_size = size; bus.dm_signed = sgn;
    st = 1'b1;
    r_be = '0;
    for (int n = 0; n < 20 && st; n++) begin
      @(negedge clk);
      st = bus.dm_stall;
      r_be = ram1_be;
      @(posedge clk); #1;
    end
    r_acc = !st;
    bus.dm_req = 1'b0;
    r_valid = 1'b0; r_fault = 1'b0; r_do = '0; r_stalls = 0; r_lat = -1;
    r_io_en = 1'b0; r_io_we = 1'b0; r_io_addr = '0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (n == 0) begin r_io_en = io_en; r_io_we = io_we; r_io_addr = io_addr; end
      if (bus.dm_valid) begin
        got = 1'b1; r_valid = 1'b1; r_fault = bus.dm_fault; r_do = bus.dm_do; r_lat = n + 1;
      end else if (bus.dm_stall) begin
        r_stalls++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    r_after = bus.dm_valid | bus.dm_fault;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, di, exp_do;
    logic [1:0] size;
    logic we, sgn, exp_fault, in_ram, in_io;
    logic [3:0] exp_be;
    int n, kind, w0;
    bit seen;

    for (int k = 0; k < WORDS; k++) begin
      seed[k] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*k+b] = 8'(seed[k] >> (8*b));
    end
    resetb = 1'b0; mem_load = 1'b1; fence_i = 1'b0; im_addr = '0;
    io_lat = 1; io_rdata = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_di = '0;
    bus.dm_size = '0; bus.dm_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.dm_valid), 0);
    chk("rst_fault", 32'(bus.dm_fault), 0);
    chk("rst_stall", 32'(bus.dm_stall), 0);
    chk("rst_io", 32'({io_en, io_we}), 0);
    chk("rst_ram0_we", 32'(ram0_we), 0);
    chk("rst_fence_done", 32'(fence_i_done), 0);
    chk("rst_be", 32'(ram1_be), 0);
    chk("rst_do", bus.dm_do, 0);
    @(posedge clk); #1;
    mem_load = 1'b0; resetb = 1'b1;
    @(posedge clk); #1;

    // store byte 0xA5 at 0x102, then signed byte load
    access(1'b1, 32'h102, 32'h0000_00A5, 2'd0, 1'b0);
    ref_mem[32'h102] = 8'hA5;
    chk("sb_be", 32'(r_be), 32'b0100);
    chk("sb_valid", 32'({r_valid, r_fault}), 32'b10);
    chk("sb_pulse", 32'(r_after), 0);
    access(1'b0, 32'h102, 32'h0, 2'd0, 1'b1);
    chk("lb_do", r_do, 32'hFFFF_FFA5);
    chk("lb_lat", 32'(r_lat), 1);
    chk("lb_stall", 32'(r_stalls), 0);

    // misaligned word load
    access(1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
    chk("lw_mis_fault", 32'({r_valid, r_fault}), 32'b11);
    chk("lw_mis_be", 32'(r_be), 0);
    chk("lw_mis_do", r_do, 0);
    chk("lw_mis_pulse", 32'(r_after), 0);

    // I/O load, ready in the third wait cycle
    io_lat = 3; io_rdata = $urandom;
    access(1'b0, IO_BASE + 4, 32'h0, 2'd2, 1'b0);
    chk("io_stalls", 32'(r_stalls), 3);
    chk("io_do", r_do, io_rdata);
    chk("io_addr", 32'(r_io_addr), 4);
    chk("io_en", 32'({r_io_en, r_io_we}), 32'b10);

    // I/O timeout
    io_lat = 0;
    access(1'b1, IO_BASE + 8, 32'h1234, 2'd2, 1'b0);
    chk("tmo_fault", 32'({r_valid, r_fault}), 32'b11);
    chk("tmo_stalls", 32'(r_stalls), IO_TMO);
    chk("tmo_io_released", 32'(io_en), 0);

    // random traffic against the byte model
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n = 1 << size;
      we = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      di = $urandom;
      io_lat = $urandom_range(1, 4);
      io_rdata = $urandom;
      if (kind <= 5) addr = $urandom_range(0, 4*WORDS - 1);
      else if (kind <= 7) addr = IO_BASE + $urandom_range(0, 255);
      else case ($urandom_range(0, 3))
        0: addr = 4*WORDS + $urandom_range(0, 4000);
        1: addr = IO_BASE - 4;
        2: addr = IO_BASE + 256;
        default: addr = 32'hFFFF_FFFC;
      endcase
      if (size != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~32'(n - 1);
      in_ram = addr < 4*WORDS;
      in_io = (addr >= IO_BASE) && (addr - IO_BASE < 256);
      exp_fault = (size == 2'd3) || ((addr % n) != 0) || !(in_ram || in_io);
      exp_be = '0;
      if (!exp_fault && in_ram && we)
        for (int i = 0; i < n; i++) exp_be[(addr + i) % 4] = 1'b1;

      access(we, addr, di, size, sgn);
      chk("rnd_accept", 32'(r_acc), 1);
      chk("rnd_valid", 32'(r_valid), 1);
      chk("rnd_fault", 32'(r_fault), 32'(exp_fault));
      chk("rnd_be", 32'(r_be), 32'(exp_be));
      chk("rnd_pulse", 32'(r_after), 0);
      if (exp_fault) begin
        chk("rnd_fault_do", r_do, 0);
        chk("rnd_fault_io", 32'(r_io_en), 0);
        chk("rnd_fault_lat", 32'(r_lat), 1);
      end else if (in_ram) begin
        chk("rnd_ram_lat", 32'(r_lat), 1);
        if (we) for (int i = 0; i < n; i++) ref_mem[addr+i] = 8'(di >> (8*i));
        else chk("rnd_ram_do", r_do, ref_load(addr, n, sgn));
      end else begin
        chk("rnd_io_addr", 32'(r_io_addr), addr - IO_BASE);
        chk("rnd_io_we", 32'({r_io_en, r_io_we}), 32'({1'b1, we}));
        chk("rnd_io_stalls", 32'(r_stalls), io_lat);
        if (!we) begin
          exp_do = io_load(io_rdata, addr, n, sgn);
          chk("rnd_io_do", r_do, exp_do);
        end
      end
    end

    // fence: copy ram1 into ram0
    w0 = r0_writes;
    fence_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < WORDS + 20 && !seen; c++) begin
      @(negedge clk);
      seen = fence_i_done;
      @(posedge clk); #1;
    end
    chk("fence_done", 32'(seen), 1);
    chk("fence_writes", 32'(r0_writes - w0), WORDS);
    for (int k = 0; k < WORDS; k++) chk("fence_copy", mem0[k], ref_word(k));
    repeat (3) begin
      @(negedge clk);
      chk("fence_done_held", 32'({fence_i_done, bus.dm_stall}), 32'b11);
      @(posedge clk); #1;
    end
    fence_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("fence_done_drop", 32'({fence_i_done, bus.dm_stall}), 0);
    for (int k = 5; k < 9; k++) begin
      @(posedge clk); #1;
      im_addr = 32'(4*k);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fetch", im_do, ref_word(k));
    end
    @(posedge clk); #1;

    // reset while the fence pointer is at 7
    fence_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = ram0_we && (ram0_addr == 6);
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("fence_ptr7_reached", 32'(seen), 1);
    resetb = 1'b0; fence_i = 1'b0;
    w0 = r0_writes;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_fence_we", 32'(ram0_we), 0);
    chk("rst_fence_done", 32'({fence_i_done, bus.dm_stall}), 0);
    @(posedge clk); #1;
    resetb = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_fence_nowrite", 32'(r0_writes - w0), 0);
    access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    chk("post_rst_load", r_do, ref_word(16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmu_gen2.md
MMU_GEN2 -- requirements
Module: mmu_gen2

Interface
REQ-001 Parameter RAM_AW, default 14: word-address width of each RAM port; RAM holds 2^RAM_AW 32-bit words.
REQ-002 Parameter IO_BASE, default 32'h8000_0000: base of the I/O window.
REQ-003 Parameter IO_AW, default 8: I/O window is 2^IO_AW bytes.
REQ-004 Parameter IO_TIMEOUT, default 15: maximum I/O wait cycles before a bus fault.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 resetb  in  1  synchronous, active-low reset.
REQ-007 im_addr  in  32  instruction fetch byte address.
REQ-008 im_do  out  32  fetched word, equal to ram0_do.
REQ-009 dm_req  in  1  data access request, held until accepted.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr / dm_di  in  32 / 32  data byte address / store data, right-aligned.
REQ-012 dm_size / dm_signed  in  2 / 1  size 0=byte, 1=half, 2=word, 3=illegal; sign-extend loads.
REQ-013 dm_do  out  32  load data, aligned and extended.
REQ-014 dm_valid / dm_stall / dm_fault  out  1 / 1 / 1  access complete / hold requester / access aborted.
REQ-015 ram0_addr, ram1_addr  out  RAM_AW  word addresses; ram0 = fetch/fill port, ram1 = data port.
REQ-016 ram0_we / ram1_be  out  1 / 4  ram0 write enable; ram1 per-byte write enables.
REQ-017 ram0_di, ram1_di / ram0_do, ram1_do  out 32 / in 32  RAM write data / RAM read data, one-cycle read latency.
REQ-018 io_en / io_we / io_addr / io_wdata  out  1 / 1 / IO_AW / 32  I/O request strobe, write, offset, write data.
REQ-019 io_rdata / io_ready  in  32 / 1  I/O read data, completion handshake.
REQ-020 fence_i / fence_i_done  in 1 / out 1  copy request / copy complete.

Function
REQ-021 Decode: dm_addr < 4*2^RAM_AW -> RAM; IO_BASE <= dm_addr < IO_BASE+2^IO_AW -> IO; otherwise unmapped.
REQ-022 Byte enables: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-023 Store data: replicated into lane position, e.g. byte at addr[1:0]=2 -> di[7:0] on bits 23:16.
REQ-024 Fault, no RAM or IO side effect: half with addr[0]=1, word with addr[1:0]!=0, dm_size=3, unmapped address.
REQ-025 FSM states: IDLE, RAM_RD, IO_WAIT, FENCE, DONE.
REQ-026 IDLE + RAM request: drive ram1 in the same cycle; a store completes with dm_valid the next cycle; a load goes to RAM_RD and asserts dm_valid with dm_do in the following cycle, giving 1-cycle latency with no stall.
REQ-027 IDLE + IO request: go to IO_WAIT; io_en, io_we, io_addr and io_wdata are registered and held stable while in IO_WAIT; dm_stall=1 while in IO_WAIT.
REQ-028 IO_WAIT: when io_ready=1, capture io_rdata, assert dm_valid for 1 cycle and go to IDLE; if IO_TIMEOUT cycles pass without io_ready, assert dm_fault for 1 cycle and go to IDLE.
REQ-029 Fault: dm_fault and dm_valid pulse together for 1 cycle after the request; dm_do=0.
REQ-030 Load extend: picks the lane selected by the registered addr[1:0] and size; zero- or sign-extends according to the registered dm_signed.
REQ-031 IDLE + fence_i=1 with no pending dm_req: go to FENCE; fence_i takes priority over a dm_req in the same cycle.
REQ-032 FENCE: pointer p runs 0..2^RAM_AW; ram1_addr=p; ram0_addr=p-1, ram0_di=ram1_do, ram0_we=1 for p>=1; dm_stall=1 throughout.
REQ-033 After word 2^RAM_AW-1 is written: go to DONE; fence_i_done=1 until fence_i=0, then go to IDLE.
REQ-034 Outside FENCE: ram0_addr=im_addr[RAM_AW+1:2] and ram0_we=0.
REQ-035 dm_req during FENCE or DONE is ignored; the requester stays stalled.

Reset
REQ-036 With resetb=0 at a clock edge: state=IDLE, pointer=0, timeout counter=0.
REQ-037 Outputs under reset: dm_valid, dm_fault, dm_stall, io_en, io_we, ram0_we, fence_i_done = 0; ram1_be=0; dm_do=0.
REQ-038 Reset mid-operation (IO_WAIT or FENCE) abandons the operation at once and causes no further RAM or IO writes.

Verification
REQ-039 Store byte 0xA5 at 0x102, then load signed byte from 0x102 -> ram1_be=4'b0100; dm_do=0xFFFFFFA5 one cycle after the load.
REQ-040 Load word from 0x102 -> dm_fault=1 and dm_valid=1 for 1 cycle; ram1_be=0.
REQ-041 Load from IO_BASE+4 with io_ready raised after 3 cycles -> dm_stall=1 for 3 cycles; dm_do=io_rdata; io_addr=4.
REQ-042 IO access with io_ready never raised -> dm_fault after IO_TIMEOUT cycles; back to IDLE.
REQ-043 fence_i with RAM_AW=4 -> 16 ram0 writes with ram0 word k = ram1 word k; fence_i_done held until fence_i drops.
REQ-044 resetb=0 at pointer=7 during FENCE -> ram0_we=0 on the next cycle; IDLE; fence_i_done=0.
